// File: rtl/conv_scale_loader_if.sv
// Stream and control bundle between the parameter buffer / multiplier side
// and the conv scale loader. The loader itself sits on the slave modport.
interface conv_scale_loader_if #(
   parameter int CHANNEL_OUT_NUM = 8,
   parameter int WIDTH_DATA_ADD  = 32,
   parameter int GROUP_NUM_WIDTH = 8
);
   logic                                      Start;
   logic [GROUP_NUM_WIDTH-1:0]                Group_Num;
   logic                                      S_Valid;
   logic [WIDTH_DATA_ADD-1:0]                 S_Data;
   logic                                      S_Ready;
   logic [WIDTH_DATA_ADD*CHANNEL_OUT_NUM-1:0] Scale_Data;
   logic                                      Scale_Valid;
   logic                                      Scale_Next;
   logic                                      Load_Done;

   // Environment side: issues loads, streams words, consumes vectors.
   modport master (
      output Start, Group_Num, S_Valid, S_Data, Scale_Next,
      input  S_Ready, Scale_Data, Scale_Valid, Load_Done
   );

   // Loader side.
   modport slave (
      input  Start, Group_Num, S_Valid, S_Data, Scale_Next,
      output S_Ready, Scale_Data, Scale_Valid, Load_Done
   );
endinterface

// File: rtl/conv_scale_loader.sv
// Conv scale loader: packs CHANNEL_OUT_NUM streamed scale words into a shadow
// vector, then moves it into the active vector seen by the multiplier once the
// active slot is free or being released. Loads Group_Num groups per Start.
module conv_scale_loader #(
   parameter int CHANNEL_OUT_NUM = 8,
   parameter int WIDTH_DATA_ADD  = 32,
   parameter int GROUP_NUM_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   conv_scale_loader_if.slave bus
);
   localparam int VEC_W = CHANNEL_OUT_NUM * WIDTH_DATA_ADD;
   localparam int CNT_W = (CHANNEL_OUT_NUM > 1) ? $clog2(CHANNEL_OUT_NUM) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CHANNEL_OUT_NUM - 1);

   typedef enum logic {IDLE, LOAD} state_e;

   state_e                     state_q,         state_d;
   logic [CNT_W-1:0]           word_cnt_q,      word_cnt_d;
   logic [GROUP_NUM_WIDTH-1:0] group_num_q,     group_num_d;
   logic [GROUP_NUM_WIDTH-1:0] groups_filled_q, groups_filled_d;
   logic [GROUP_NUM_WIDTH-1:0] groups_moved_q,  groups_moved_d;
   logic [VEC_W-1:0]           shadow_q,        shadow_d;
   logic                       shadow_full_q,   shadow_full_d;
   logic [VEC_W-1:0]           active_q,        active_d;
   logic                       scale_valid_q,   scale_valid_d;
   logic                       load_done_q,     load_done_d;

   logic s_ready;
   logic accept;
   logic transfer;

   // Next-state, packing, transfer and consume decisions for one clock.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d         = state_q;
      word_cnt_d      = word_cnt_q;
      group_num_d     = group_num_q;
      groups_filled_d = groups_filled_q;
      groups_moved_d  = groups_moved_q;
      shadow_d        = shadow_q;
      shadow_full_d   = shadow_full_q;
      active_d        = active_q;
      scale_valid_d   = scale_valid_q;
      load_done_d     = 1'b0;

      // Only take words while loading, with room in shadow and groups still owed.
      s_ready  = (state_q == LOAD) && !shadow_full_q && (groups_filled_q < group_num_q);
      accept   = s_ready && bus.S_Valid;
      // Active slot is free, or its current group is being released this edge.
      transfer = shadow_full_q && (!scale_valid_q || bus.Scale_Next);

      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               group_num_d     = bus.Group_Num;
               word_cnt_d      = '0;
               groups_filled_d = '0;
               groups_moved_d  = '0;
               if (bus.Group_Num == '0) begin
                  load_done_d = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            // Start is deliberately ignored while a load is in flight.
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         shadow_d[int'(word_cnt_q) * WIDTH_DATA_ADD +: WIDTH_DATA_ADD] = bus.S_Data;
         if (word_cnt_q == LAST_WORD) begin
            word_cnt_d      = '0;
            shadow_full_d   = 1'b1;
            groups_filled_d = groups_filled_q + GROUP_NUM_WIDTH'(1);
         end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
         end
      end

      // A transfer wins over a plain consume so Scale_Valid stays high across a swap.
      if (transfer) begin
         active_d       = shadow_q;
         scale_valid_d  = 1'b1;
         shadow_full_d  = 1'b0;
         groups_moved_d = groups_moved_q + GROUP_NUM_WIDTH'(1);
         if ((groups_moved_q + GROUP_NUM_WIDTH'(1)) == group_num_q) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
         end
      end else if (bus.Scale_Next && scale_valid_q) begin
         scale_valid_d = 1'b0;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         word_cnt_q      <= '0;
         group_num_q     <= '0;
         groups_filled_q <= '0;
         groups_moved_q  <= '0;
         // NOTE: the vector registers are reset too, so a load abandoned by reset leaves no stale words.
         shadow_q        <= '0;
         shadow_full_q   <= 1'b0;
         active_q        <= '0;
         scale_valid_q   <= 1'b0;
         load_done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops update together from pre-edge values.
         state_q         <= state_d;
         word_cnt_q      <= word_cnt_d;
         group_num_q     <= group_num_d;
         groups_filled_q <= groups_filled_d;
         groups_moved_q  <= groups_moved_d;
         shadow_q        <= shadow_d;
         shadow_full_q   <= shadow_full_d;
         active_q        <= active_d;
         scale_valid_q   <= scale_valid_d;
         load_done_q     <= load_done_d;
      end
   end

   assign bus.S_Ready     = s_ready;
   assign bus.Scale_Data  = active_q;
   assign bus.Scale_Valid = scale_valid_q;
   assign bus.Load_Done   = load_done_q;

endmodule

// File: tb/tb_conv_scale_loader.sv
// Self-checking bench for conv_scale_loader. A word queue models the stream:
// every accepted word is queued, and each newly presented vector must equal
// the next CHANNEL_OUT_NUM queued words packed with the first word in the LSBs.
module tb_conv_scale_loader;
   localparam int N  = 8;
   localparam int W  = 32;
   localparam int GW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   conv_scale_loader_if #(.CHANNEL_OUT_NUM(N), .WIDTH_DATA_ADD(W), .GROUP_NUM_WIDTH(GW)) bus ();

   conv_scale_loader #(.CHANNEL_OUT_NUM(N), .WIDTH_DATA_ADD(W), .GROUP_NUM_WIDTH(GW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [W-1:0] sent_q[$];
   bit           need_check = 1'b1;
   bit           prev_valid = 1'b0;
   int           words_acc  = 0;
   int           ld_cnt     = 0;
   int           vec_seen   = 0;
   int           b2b_valid  = 0;

   task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Compare the presented vector with the next N words of the stream model.
   task automatic check_vec();
      logic [N*W-1:0] exp = '0;
      if (sent_q.size() < N) begin
         check("vec_words_available", sent_q.size(), N);
         return;
      end
      for (int i = 0; i < N; i++) exp[i*W +: W] = sent_q.pop_front();
      vec_seen++;
      check("scale_vector", bus.Scale_Data, exp);
   endtask

   // One clock: drive inputs at posedge+1, note handshakes, advance, observe.
   task automatic cycle(input logic sv, input logic [W-1:0] sd, input logic nx,
                        input logic st = 1'b0, input logic [GW-1:0] gn = '0);
      bit took;
      bit consume;
      bus.S_Valid    = sv;
      bus.S_Data     = sd;
      bus.Scale_Next = nx;
      bus.Start      = st;
      bus.Group_Num  = gn;
      #1;
      took    = sv && bus.S_Ready;
      consume = nx && bus.Scale_Valid;
      if (took) begin
         sent_q.push_back(sd);
         words_acc++;
      end
      @(posedge clk);
      #1;
      if (consume) need_check = 1'b1;
      if (bus.Load_Done) ld_cnt++;
      if (bus.Scale_Valid && prev_valid) b2b_valid++;
      prev_valid = bus.Scale_Valid;
      if (bus.Scale_Valid && need_check) begin
         check_vec();
         need_check = 1'b0;
      end
   endtask

   task automatic clear_stats();
      words_acc = 0;
      ld_cnt    = 0;
      vec_seen  = 0;
      b2b_valid = 0;
   endtask

   initial begin
      logic [N*W-1:0] exp_vec;
      bit             ok;
      int             c;

      bus.Start = 1'b0; bus.Group_Num = '0; bus.S_Valid = 1'b0;
      bus.S_Data = '0;  bus.Scale_Next = 1'b0;

      // Reset state.
      #2;
      check("rst_s_ready",     bus.S_Ready,     1'b0);
      check("rst_scale_valid", bus.Scale_Valid, 1'b0);
      check("rst_scale_data",  bus.Scale_Data,  '0);
      check("rst_load_done",   bus.Load_Done,   1'b0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Single group, words 1..8 back-to-back, no consumption.
      clear_stats();
      cycle(1'b0, '0, 1'b0, 1'b1, 8'd1);
      ok = 1'b1;
      for (int k = 1; k <= N; k++) begin
         if (bus.S_Ready !== 1'b1) ok = 1'b0;
         cycle(1'b1, W'(k), 1'b0);
      end
      check("t1_ready_every_word",   ok,              1'b1);
      check("t1_ready_low_after_w8", bus.S_Ready,     1'b0);
      check("t1_valid_not_yet",      bus.Scale_Valid, 1'b0);
      cycle(1'b0, '0, 1'b0);
      for (int i = 0; i < N; i++) exp_vec[i*W +: W] = W'(i + 1);
      check("t1_valid_rises",     bus.Scale_Valid, 1'b1);
      check("t1_data",            bus.Scale_Data,  exp_vec);
      check("t1_load_done",       bus.Load_Done,   1'b1);
      check("t1_ready_stays_low", bus.S_Ready,     1'b0);
      cycle(1'b0, '0, 1'b0);
      check("t1_load_done_single", bus.Load_Done,   1'b0);
      check("t1_valid_held",       bus.Scale_Valid, 1'b1);
      cycle(1'b0, '0, 1'b1);
      check("t1_consumed",  bus.Scale_Valid, 1'b0);
      check("t1_data_kept", bus.Scale_Data,  exp_vec);

      // Three groups streamed continuously, consumer always ready.
      clear_stats();
      cycle(1'b0, '0, 1'b1, 1'b1, 8'd3);
      for (int k = 0; k < 40; k++) cycle(1'b1, 32'h1000_0000 + W'(k), 1'b1);
      check("t2_vectors",     vec_seen,        3);
      check("t2_words",       words_acc,       24);
      check("t2_load_done",   ld_cnt,          1);
      check("t2_single_beat", b2b_valid,       0);
      check("t2_idle_valid",  bus.Scale_Valid, 1'b0);

      // Two groups, consumer stalled: second group parks in shadow.
      clear_stats();
      cycle(1'b0, '0, 1'b0, 1'b1, 8'd2);
      for (int k = 0; k < 20; k++) cycle(1'b1, $urandom, 1'b0);
      check("t3_words",         words_acc,       16);
      check("t3_first_active",  vec_seen,        1);
      check("t3_valid",         bus.Scale_Valid, 1'b1);
      check("t3_ready_blocked", bus.S_Ready,     1'b0);
      check("t3_no_done_yet",   ld_cnt,          0);
      cycle(1'b0, '0, 1'b1);
      check("t3_swap_valid",  bus.Scale_Valid, 1'b1);
      check("t3_swap_vector", vec_seen,        2);
      check("t3_load_done",   bus.Load_Done,   1'b1);
      cycle(1'b0, '0, 1'b0);
      check("t3_done_single", bus.Load_Done, 1'b0);
      cycle(1'b0, '0, 1'b1);
      check("t3_consumed", bus.Scale_Valid, 1'b0);

      // Zero-group load.
      clear_stats();
      cycle(1'b1, $urandom, 1'b0, 1'b1, 8'd0);
      check("t4_load_done", bus.Load_Done, 1'b1);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, $urandom, 1'b0);
         if (bus.S_Ready !== 1'b0 || bus.Scale_Valid !== 1'b0) ok = 1'b0;
      end
      check("t4_quiet",       ok,        1'b1);
      check("t4_no_words",    words_acc, 0);
      check("t4_done_single", ld_cnt,    1);

      // Reset after five words, then a clean reload.
      cycle(1'b0, '0, 1'b0, 1'b1, 8'd1);
      for (int k = 0; k < 5; k++) cycle(1'b1, 32'hDEAD_0000 + W'(k), 1'b0);
      bus.S_Valid = 1'b0;
      rst = 1'b0;
      #1;
      check("t5_rst_ready", bus.S_Ready,     1'b0);
      check("t5_rst_valid", bus.Scale_Valid, 1'b0);
      check("t5_rst_data",  bus.Scale_Data,  '0);
      check("t5_rst_done",  bus.Load_Done,   1'b0);
      sent_q.delete();
      need_check = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      clear_stats();
      cycle(1'b0, '0, 1'b0, 1'b1, 8'd1);
      for (int k = 0; k < N; k++) cycle(1'b1, 32'h5A00_0000 + W'(k), 1'b0);
      cycle(1'b0, '0, 1'b0);
      for (int i = 0; i < N; i++) exp_vec[i*W +: W] = 32'h5A00_0000 + W'(i);
      check("t5_fresh_vector", bus.Scale_Data, exp_vec);
      check("t5_fresh_valid",  bus.Scale_Valid, 1'b1);
      cycle(1'b0, '0, 1'b1);

      // Random gaps and stalls, four groups, a second Start mid-load.
      clear_stats();
      cycle(1'b0, '0, 1'b0, 1'b1, 8'd4);
      c = 0;
      while (!(vec_seen == 4 && bus.Scale_Valid === 1'b0) && c < 3000) begin
         cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0),
               (c == 12), 8'd2);
         c++;
      end
      check("t6_finished_in_budget", (c < 3000), 1'b1);
      check("t6_words",       words_acc,      32);
      check("t6_vectors",     vec_seen,       4);
      check("t6_load_done",   ld_cnt,         1);
      check("t6_queue_empty", sent_q.size(),  0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
